fb_write_arbiter: RTL and testbench

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

---
 rtl/fb_write_arbiter.sv | 107 ++++++++++
 tb/tb_fb_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_write_arbiter.sv
// Two-channel round-robin arbiter feeding a single registered frame-buffer write port.
// Channel commands are translated to absolute word addresses; zero-mask commands are dropped.
module fb_write_arbiter #(
  parameter logic [27:0] FB_BASE      = 28'h0100000,
  parameter logic [27:0] FRAME_STRIDE = 28'h0040000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [53:0] in0_dout,
  input  logic        in0_valid,
  output logic        in0_ready,
  input  logic [53:0] in1_dout,
  input  logic        in1_valid,
  output logic        in1_ready,
  output logic [27:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [3:0]  mem_mask,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        idle,
  output logic [19:0] wr_count
);

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned CNT_W  = 20;

  typedef struct packed {
    logic [3:0]  mask;
    logic        frame;
    logic [16:0] addr;
    logic [31:0] pixel;
  } cmd_t;

  cmd_t              cmd0;
  cmd_t              cmd1;
  cmd_t              sel_cmd;
  logic              can_load;
  logic              grant_any;
  logic              grant_ch;
  logic              last_grant;
  logic              accept;
  logic              load;
  logic [ADDR_W-1:0] frame_off;
  logic [ADDR_W-1:0] load_addr;

  assign cmd0 = cmd_t'(in0_dout);
  assign cmd1 = cmd_t'(in1_dout);

  assign can_load = ~mem_valid | mem_ready;

  // Round-robin: on a tie the channel that did not win last time gets the grant.
  always_comb begin
    grant_any = 1'b0;
    grant_ch  = 1'b0;
    case ({in1_valid, in0_valid})
      2'b01: begin grant_any = 1'b1; grant_ch = 1'b0; end
      2'b10: begin grant_any = 1'b1; grant_ch = 1'b1; end
      2'b11: begin grant_any = 1'b1; grant_ch = ~last_grant; end
      default: begin grant_any = 1'b0; grant_ch = 1'b0; end
    endcase
  end

  assign in0_ready = grant_any & ~grant_ch & can_load & ~reset;
  assign in1_ready = grant_any &  grant_ch & can_load & ~reset;

  assign accept  = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign sel_cmd = grant_ch ? cmd1 : cmd0;
  assign load    = accept & (sel_cmd.mask != 4'b0000);

  assign frame_off = sel_cmd.frame ? FRAME_STRIDE : ADDR_W'(0);
  assign load_addr = FB_BASE + frame_off + ADDR_W'(sel_cmd.addr);

  assign idle = ~mem_valid & ~in0_valid & ~in1_valid;

  // Output register; a retire without a fresh load empties it.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_mask   <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        last_grant <= grant_ch;
      end
      if (load) begin
        mem_valid <= 1'b1;
        mem_addr  <= load_addr;
        mem_data  <= sel_cmd.pixel;
        mem_mask  <= sel_cmd.mask;
      end else if (mem_ready) begin
        mem_valid <= 1'b0;
      end
    end
  end

  // Completed-write counter, saturating.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_count <= '0;
    end else if (mem_valid && mem_ready && (wr_count != {CNT_W{1'b1}})) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomized plus directed bench for fb_write_arbiter against a transaction-level model:
// a queue of expected memory writes, a round-robin "last winner" and a saturating count.
module tb_fb_write_arbiter;

  logic        clock;
  logic        reset;
  logic [53:0] in0_dout;
  logic        in0_valid;
  logic        in0_ready;
  logic [53:0] in1_dout;
  logic        in1_valid;
  logic        in1_ready;
  logic [27:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_mask;
  logic        mem_valid;
  logic        mem_ready;
  logic        idle;
  logic [19:0] wr_count;

  fb_write_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .in0_dout  (in0_dout),
    .in0_valid (in0_valid),
    .in0_ready (in0_ready),
    .in1_dout  (in1_dout),
    .in1_valid (in1_valid),
    .in1_ready (in1_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_mask  (mem_mask),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .idle      (idle),
    .wr_count  (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [27:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  wr_t         exp_q[$];
  int          m_last;
  logic [19:0] m_cnt;
  int          last_acc;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic wr_t expect_of(input logic [53:0] c);
    longint sum;
    wr_t w;
    sum = 64'h0100000 + (c[49] ? 64'h0040000 : 64'h0) + longint'(c[48:32]);
    w.a = 28'(sum % (64'h1 << 28));
    w.d = c[31:0];
    w.m = c[53:50];
    return w;
  endfunction

  function automatic logic [53:0] rand_cmd();
    logic [53:0] c;
    c[31:0]  = $urandom;
    c[48:32] = 17'($urandom);
    c[49]    = 1'($urandom);
    c[53:50] = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    return c;
  endfunction

  task automatic check_regs();
    check("mem_valid", mem_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("mem_addr", mem_addr, exp_q[0].a);
      check("mem_data", mem_data, exp_q[0].d);
      check("mem_mask", mem_mask, exp_q[0].m);
    end
    check("wr_count", wr_count, m_cnt);
  endtask

  // One clock cycle: called at posedge+1, drives inputs, checks handshakes, advances model.
  task automatic step(input logic v0, input logic [53:0] d0, input logic v1,
                      input logic [53:0] d1, input logic mr);
    bit can;
    int g;
    in0_valid = v0; in0_dout = d0;
    in1_valid = v1; in1_dout = d1;
    mem_ready = mr;
    #1;
    can = (exp_q.size() == 0) || mr;
    g = -1;
    if (v0 && v1) g = (m_last == 1) ? 0 : 1;
    else if (v0) g = 0;
    else if (v1) g = 1;
    check("in0_ready", in0_ready, can && g == 0);
    check("in1_ready", in1_ready, can && g == 1);
    check("idle", idle, exp_q.size() == 0 && !v0 && !v1);
    last_acc = (can && g >= 0) ? g : -1;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0 && mr) begin
      void'(exp_q.pop_front());
      if (m_cnt != 20'hFFFFF) m_cnt = m_cnt + 20'd1;
    end
    if (last_acc >= 0) begin
      m_last = last_acc;
      if (last_acc == 0 && d0[53:50] != 4'b0000) exp_q.push_back(expect_of(d0));
      if (last_acc == 1 && d1[53:50] != 4'b0000) exp_q.push_back(expect_of(d1));
    end
    check_regs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; mem_ready = 1'b0;
    #1;
    check("rst_in0_ready", in0_ready, 1'b0);
    check("rst_in1_ready", in1_ready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_cnt  = '0;
    m_last = 1;
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 28'h0);
    check("rst_mem_data", mem_data, 32'h0);
    check("rst_mem_mask", mem_mask, 4'h0);
    check("rst_wr_count", wr_count, 20'h0);
    check("rst_idle", idle, 1'b1);
  endtask

  logic [53:0] c0, c1;
  logic [27:0] hold_a;
  logic [31:0] hold_d;
  logic [19:0] hold_cnt;

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; mem_ready = 1'b0;
    in0_dout = '0; in1_dout = '0;
    m_last = 1; m_cnt = '0; last_acc = -1;
    @(posedge clock);
    #1;
    do_reset();

    // Single overlay command with a known translated address.
    c1 = {4'b0100, 1'b1, 17'd1300, 32'h02020202};
    step(1'b0, '0, 1'b1, c1, 1'b1);
    check("single_addr", mem_addr, 28'h0140514);
    check("single_mask", mem_mask, 4'b0100);
    check("single_data", mem_data, 32'h02020202);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("single_count", wr_count, 20'd1);

    // Both channels saturated: strict alternation starting with channel 0.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      c0 = rand_cmd(); c0[53:50] = 4'hF;
      c1 = rand_cmd(); c1[53:50] = 4'h3;
      step(1'b1, c0, 1'b1, c1, 1'b1);
      check("alt_grant", last_acc, i % 2);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("alt_count", wr_count, 20'd8);

    // Backpressure: entry holds for 5 cycles, then retires on the first ready.
    c0 = rand_cmd(); c0[53:50] = 4'h5;
    step(1'b1, c0, 1'b0, '0, 1'b1);
    hold_a = mem_addr; hold_d = mem_data; hold_cnt = wr_count;
    for (int i = 0; i < 5; i++) begin
      c0 = rand_cmd(); c1 = rand_cmd();
      step(1'b1, c0, 1'b1, c1, 1'b0);
      check("stall_addr", mem_addr, hold_a);
      check("stall_data", mem_data, hold_d);
    end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    check("stall_retire", wr_count, hold_cnt + 20'd1);

    // Zero-mask command is consumed but never written.
    hold_cnt = wr_count;
    step(1'b1, {4'b0000, 1'b0, 17'd0, 32'hDEADBEEF}, 1'b0, '0, 1'b1);
    check("zmask_valid", mem_valid, 1'b0);
    check("zmask_count", wr_count, hold_cnt);

    // Reset with a stalled entry drops it and restores channel-0 tie priority.
    c0 = rand_cmd(); c0[53:50] = 4'h9;
    step(1'b1, c0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    do_reset();
    c0 = rand_cmd(); c0[53:50] = 4'h1;
    c1 = rand_cmd(); c1[53:50] = 4'h2;
    step(1'b1, c0, 1'b1, c1, 1'b1);
    check("post_rst_tie", last_acc, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      c0 = rand_cmd(); c1 = rand_cmd();
      step(1'($urandom_range(0, 2) != 0), c0, 1'($urandom_range(0, 2) != 0), c1,
           1'($urandom_range(0, 3) != 0));
    end

    // Counter saturation from a preloaded value near the limit.
    step(1'b0, '0, 1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    force dut.wr_count = 20'hFFFFD;
    #1;
    release dut.wr_count;
    m_cnt = 20'hFFFFD;
    for (int i = 0; i < 10; i++) begin
      c0 = rand_cmd(); c0[53:50] = 4'hA;
      step(1'b1, c0, 1'b0, '0, 1'b1);
    end
    check("sat_count", wr_count, 20'hFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
